// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start bit, 8 data bits LSB first,
// odd parity, stop bit and device acknowledge, with inactivity timeout on the device clock.
module ps2_tx #(
  parameter int RTS_CYCLES     = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_ok,
  output logic       tx_err_tick
);

  localparam int RTS_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RTS_W-1:0] RTS_LOAD = RTS_W'(RTS_CYCLES - 1);
  // The increment that would make the timer reach TIMEOUT_CYCLES-1 aborts instead,
  // so the registered error tick lands TIMEOUT_CYCLES cycles after the last fall_edge.
  localparam logic [TO_W-1:0]  TO_ABORT = TO_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP
  } state_e;

  state_e           state_q;
  logic [7:0]       filter_q, filter_d;
  logic             fps2c_q, fps2c_d;
  logic             fall_edge;
  logic [8:0]       shift_q;
  logic [RTS_W-1:0] rts_cnt_q;
  logic [TO_W-1:0]  tmr_q;
  logic [3:0]       bit_cnt_q;
  logic             ps2c_oe_q, ps2d_oe_q, tx_idle_q, done_q, err_q, ack_ok_q;

  always_comb begin
    filter_d = {ps2c_in, filter_q[7:1]};
    fps2c_d  = fps2c_q;
    if (filter_q == 8'hFF)      fps2c_d = 1'b1;
    else if (filter_q == 8'h00) fps2c_d = 1'b0;
    fall_edge = fps2c_q & ~fps2c_d;
  end

  // NOTE: every output is a register updated alongside the state, so the open-drain
  // enables never glitch while the next-state logic settles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      filter_q  <= '0;
      fps2c_q   <= 1'b0;
      shift_q   <= '0;
      rts_cnt_q <= '0;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      ps2c_oe_q <= 1'b0;
      ps2d_oe_q <= 1'b0;
      tx_idle_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      filter_q <= filter_d;
      fps2c_q  <= fps2c_d;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_ps2) begin
            shift_q   <= {~^din, din};
            rts_cnt_q <= RTS_LOAD;
            ps2c_oe_q <= 1'b1;
            tx_idle_q <= 1'b0;
            state_q   <= RTS;
          end
        end
        RTS: begin
          if (rts_cnt_q == '0) begin
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b1;
            tmr_q     <= '0;
            state_q   <= START;
          end else begin
            rts_cnt_q <= rts_cnt_q - RTS_W'(1);
          end
        end
        START, DATA, STOP: begin
          if (fall_edge) begin
            tmr_q <= '0;
            if (state_q == START) begin
              bit_cnt_q <= 4'd8;
              ps2d_oe_q <= ~shift_q[0];
              state_q   <= DATA;
            end else if (state_q == DATA) begin
              shift_q <= {1'b0, shift_q[8:1]};
              if (bit_cnt_q == 4'd0) begin
                ps2d_oe_q <= 1'b0;
                state_q   <= STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q - 4'd1;
                ps2d_oe_q <= ~shift_q[1];
              end
            end else begin
              ack_ok_q  <= ~ps2d_in;
              done_q    <= 1'b1;
              tx_idle_q <= 1'b1;
              state_q   <= IDLE;
            end
          end else if (tmr_q == TO_ABORT) begin
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            err_q     <= 1'b1;
            tx_idle_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            tmr_q <= tmr_q + TO_W'(1);
          end
        end
        default: begin
          ps2c_oe_q <= 1'b0;
          ps2d_oe_q <= 1'b0;
          tx_idle_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign ps2c_oe      = ps2c_oe_q;
  assign ps2d_oe      = ps2d_oe_q;
  assign tx_idle      = tx_idle_q;
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;
  assign ack_ok       = ack_ok_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a small device model clocks frames from a vector table,
// then hand-written sequences cover timeout and reset during request-to-send.
module tb_ps2_tx;

  localparam int RTS = 20;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       dev_ack;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_ok, tx_err_tick;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  int oe_hi_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int err_cyc  = 0;

  typedef struct {
    logic [7:0] din;
    logic       dev_ack;
    logic       inject_wr;
    int         glitch_len;
    logic       exp_par;
    logic       exp_ack_ok;
  } vec_t;

  vec_t vecs[6];

  ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c_in      (ps2c_in),
    .ps2d_in      (ps2d_in),
    .ps2c_oe      (ps2c_oe),
    .ps2d_oe      (ps2d_oe),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_ok       (ack_ok),
    .tx_err_tick  (tx_err_tick)
  );

  // Open-drain data wire with pull-up: low if the host or the device pulls it.
  assign ps2d_in = ~(ps2d_oe | dev_ack);

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (ps2c_oe) oe_hi_cnt++;
    if (tx_done_tick) done_cnt++;
    if (tx_err_tick) begin
      err_cnt++;
      err_cyc = cyc_cnt;
    end
    if (tx_done_tick && tx_err_tick) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < RTS + 50; i++) begin
      @(negedge clk);
      if (!ps2c_oe) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_low(input int len);
    ps2c_in = 1'b0;
    repeat (len) @(negedge clk);
    ps2c_in = 1'b1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int   done_base, err_base, oe_base;
    bit   ok;
    logic exp_bit;
    logic prev;
    done_base = done_cnt;
    err_base  = err_cnt;
    oe_base   = oe_hi_cnt;
    din    = v.din;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check($sformatf("f%0d_busy", idx), 32'(tx_idle), 32'd0);
    wait_release(ok);
    check($sformatf("f%0d_rts_release", idx), 32'(ok), 32'd1);
    check($sformatf("f%0d_rts_len", idx), 32'(oe_hi_cnt - oe_base), 32'(RTS));
    check($sformatf("f%0d_start_bit", idx), 32'(ps2d_oe), 32'd1);
    for (int k = 1; k <= 11; k++) begin
      dev_ack = (k == 11) ? v.dev_ack : 1'b0;
      ps2c_in = 1'b0;
      repeat (14) @(negedge clk);
      if (k <= 9) begin
        exp_bit = (k == 9) ? v.exp_par : v.din[k-1];
        check($sformatf("f%0d_bit%0d", idx, k - 1), 32'(ps2d_oe), 32'(!exp_bit));
      end else if (k == 10) begin
        check($sformatf("f%0d_stop_bit", idx), 32'(ps2d_oe), 32'd0);
        check($sformatf("f%0d_early_done", idx), 32'(done_cnt - done_base), 32'd0);
      end
      repeat (2) @(negedge clk);
      ps2c_in = 1'b1;
      dev_ack = 1'b0;
      repeat (6) @(negedge clk);
      if (k == 4 && v.inject_wr) begin
        din    = 8'h00;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
      if (k == 5 && v.glitch_len > 0) begin
        prev = ps2d_oe;
        pulse_low(v.glitch_len);
        repeat (10) @(negedge clk);
        check($sformatf("f%0d_glitch_hold", idx), 32'(ps2d_oe), 32'(prev));
      end
      repeat (10) @(negedge clk);
    end
    check($sformatf("f%0d_done_once", idx), 32'(done_cnt - done_base), 32'd1);
    check($sformatf("f%0d_no_err", idx), 32'(err_cnt - err_base), 32'd0);
    check($sformatf("f%0d_ack_ok", idx), 32'(ack_ok), 32'(v.exp_ack_ok));
    check($sformatf("f%0d_idle", idx), 32'(tx_idle), 32'd1);
    check($sformatf("f%0d_lines", idx), 32'({ps2c_oe, ps2d_oe}), 32'd0);
  endtask

  initial begin
    int  done_base, err_base, t0;
    bit  ok;

    // din, dev_ack, inject_wr, glitch_len, exp_par, exp_ack_ok
    vecs[0] = '{8'hF4, 1'b1, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 0, 1'b1, 1'b0};
    vecs[2] = '{8'hED, 1'b1, 1'b1, 0, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 1'b0, 1'b0, 7, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b0, 1, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 3, 1'b1, 1'b1};

    reset   = 1'b0;
    wr_ps2  = 1'b0;
    din     = 8'h00;
    ps2c_in = 1'b1;
    dev_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lines", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    check("rst_idle", 32'(tx_idle), 32'd1);
    check("rst_ticks", 32'({tx_done_tick, tx_err_tick}), 32'd0);
    check("rst_ack_ok", 32'(ack_ok), 32'd0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // Device clock activity while idle must not start anything.
    done_base = done_cnt;
    err_base  = err_cnt;
    for (int p = 0; p < 2; p++) begin
      pulse_low(16);
      repeat (16) @(negedge clk);
    end
    check("idle_fall_ignored", 32'({tx_idle, ps2c_oe, ps2d_oe}), 32'b100);
    check("idle_no_ticks", 32'((done_cnt - done_base) + (err_cnt - err_base)), 32'd0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

    // Device stops clocking after 4 data bits: start pulse plus 4 more, then silence.
    done_base = done_cnt;
    err_base  = err_cnt;
    din    = 8'hA5;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    wait_release(ok);
    check("to_rts_release", 32'(ok), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pulse_low(16);
      repeat (16) @(negedge clk);
    end
    ps2c_in = 1'b0;
    t0 = cyc_cnt;
    repeat (16) @(negedge clk);
    ps2c_in = 1'b1;
    for (int i = 0; i < TO + 50; i++) begin
      @(negedge clk);
      #1;
      if (err_cnt != err_base) break;
    end
    check("to_fired", 32'(err_cnt - err_base), 32'd1);
    // fall_edge appears 8 cycles after the line drops (filter depth), tick TO cycles later.
    check("to_latency", 32'(err_cyc - t0), 32'(8 + TO));
    repeat (2) @(negedge clk);
    check("to_lines", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    check("to_idle", 32'(tx_idle), 32'd1);
    check("to_no_done", 32'(done_cnt - done_base), 32'd0);
    check("to_ack_kept", 32'(ack_ok), 32'd1);

    // Reset asserted in the middle of request-to-send.
    done_base = done_cnt;
    err_base  = err_cnt;
    din    = 8'h55;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    repeat (5) @(negedge clk);
    check("rts_active", 32'(ps2c_oe), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_release", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    check("rst_async_idle", 32'(tx_idle), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (RTS + 20) @(negedge clk);
    check("rst_after_idle", 32'({tx_idle, ps2c_oe, ps2d_oe}), 32'b100);
    check("rst_after_ticks", 32'((done_cnt - done_base) + (err_cnt - err_base)), 32'd0);
    check("rst_after_ack", 32'(ack_ok), 32'd0);

    check("no_dual_tick", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 The module SHALL have parameter RTS_CYCLES, default 10000, giving the number of clk cycles the PS/2 clock is held low for request-to-send (100 us at 100 MHz).
REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 2000000, giving the maximum clk cycles allowed between device clock falling edges once the device is clocking (20 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately.
REQ-005 wr_ps2  input  1  one-cycle write strobe; starts a transmission of din when the module is idle.
REQ-006 din  input  8  command byte to send to the device, LSB first.
REQ-007 ps2c_in  input  1  sampled PS/2 clock line (pad input).
REQ-008 ps2d_in  input  1  sampled PS/2 data line (pad input).
REQ-009 ps2c_oe  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-010 ps2d_oe  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-011 tx_idle  output  1  1 when in idle; intended for the receiver's rx_en.
REQ-012 tx_done_tick  output  1  one-cycle pulse at normal end of a frame.
REQ-013 ack_ok  output  1  device acknowledge status of the last completed frame (1 = data sampled low at ack edge).
REQ-014 tx_err_tick  output  1  one-cycle pulse when a frame is aborted by timeout.

Function
REQ-015 ps2c_in SHALL pass through an 8-stage shift filter; the filtered clock SHALL become 1 only after 8 consecutive 1 samples and 0 only after 8 consecutive 0 samples, otherwise holding its value.
REQ-016 fall_edge SHALL be asserted for one cycle when the filtered clock is 1 and its next value is 0.
REQ-017 The FSM SHALL have states idle, rts, start, data, stop.
REQ-018 idle: tx_idle=1, ps2c_oe=0, ps2d_oe=0; on wr_ps2=1, latch 9-bit shift register {odd parity of din, din}, load RTS counter with RTS_CYCLES-1, go to rts.
REQ-019 Odd parity bit SHALL equal the inverted XOR-reduction of din, so the 9 bits contain an odd number of ones.
REQ-020 wr_ps2 outside idle SHALL be ignored, with no effect on the frame in progress.
REQ-021 rts: ps2c_oe=1, ps2d_oe=0; decrement counter each cycle; at counter 0 go to start with ps2c_oe=0 from the next cycle.
REQ-022 start: ps2c_oe=0, ps2d_oe=1 (start bit 0); on fall_edge load bit counter with 8 and go to data.
REQ-023 data: ps2d_oe = NOT shift[0]; on fall_edge shift right by one; if bit counter is 0 go to stop, else decrement it. This sends 9 bits: 8 data LSB first, then parity.
REQ-024 stop: ps2c_oe=0, ps2d_oe=0 (stop bit 1 by pull-up); on fall_edge set ack_ok = NOT ps2d_in, pulse tx_done_tick, go to idle.
REQ-025 A timeout counter SHALL clear on entry to start and on every fall_edge; in start, data and stop it SHALL increment each cycle; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to idle, release both lines, pulse tx_err_tick, and leave ack_ok unchanged.
REQ-026 fall_edge in idle or rts SHALL be ignored.
REQ-027 tx_done_tick and tx_err_tick SHALL never be asserted in the same cycle.
REQ-028 Counter widths SHALL hold their parameter values without wrap: at least clog2(RTS_CYCLES) and clog2(TIMEOUT_CYCLES) bits, 4-bit bit counter.

Reset
REQ-029 While reset=0: state=idle, filter=0, filtered clock=0, counters=0, shift register=0, ps2c_oe=0, ps2d_oe=0, ack_ok=0, tx_done_tick=0, tx_err_tick=0, tx_idle=1.
REQ-030 Reset asserted mid-frame SHALL release both lines asynchronously and drop the frame; no done or error pulse.

Verification
REQ-031 din=8'hF4, wr_ps2 pulse, device model clocks 11 falling edges with ack low -> ps2c_oe high exactly RTS_CYCLES cycles; data bits sent 0,0,1,0,1,1,1,1, parity 0; tx_done_tick once; ack_ok=1.
REQ-032 din=8'hFF, device gives ack bit high -> parity bit 1 on line; tx_done_tick once; ack_ok=0.
REQ-033 Device stops clocking after 4 data bits -> tx_err_tick exactly TIMEOUT_CYCLES cycles after the last fall_edge; lines released; tx_idle=1.
REQ-034 Glitch of 1-7 cycles low on ps2c_in during data -> no fall_edge; shift register and bit counter unchanged.
REQ-035 wr_ps2 with din=8'h00 issued during data state of an 8'hED frame -> ignored; frame transmits ED with parity 1.
REQ-036 reset low during rts -> ps2c_oe=0 in the same cycle; after release, tx_idle=1 with no ticks.
